// File: rtl/la_dmuxn_pkg.sv
// Shared constants and select-checking helpers for the la_*mux block family.
package la_dmuxn_pkg;

   localparam string       MODE_ONEHOT   = "ONEHOT";
   localparam string       MODE_PRIORITY = "PRIORITY";
   localparam int unsigned MAX_STAGES    = 4;
   localparam int unsigned SEL_MAX       = 64;

   // Selects wider than SEL_MAX are not supported by the helpers below.
   function automatic int unsigned popcount(input logic [SEL_MAX-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int unsigned i = 0; i < SEL_MAX; i++) begin
         cnt += 32'(v[i]);
      end
      return cnt;
   endfunction

   function automatic logic is_onehot(input logic [SEL_MAX-1:0] v);
      return popcount(v) == 1;
   endfunction

endpackage

// File: rtl/la_dmuxn_pipe_if.sv
// Beat, backpressure and error-flag signals of la_dmuxn_pipe.
interface la_dmuxn_pipe_if #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 1
);

   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   sel;
   logic [N*W-1:0] in;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out;
   logic           out_err;
   logic           err_sticky;
   logic           err_clear;

   modport master (
      output in_valid, sel, in, out_ready, err_clear,
      input  in_ready, out_valid, out, out_err, err_sticky
   );

   modport slave (
      input  in_valid, sel, in, out_ready, err_clear,
      output in_ready, out_valid, out, out_err, err_sticky
   );

endinterface

// File: rtl/la_dmuxn_stage.sv
// One valid/ready register slice; loads when empty or when downstream drains it,
// so bubbles collapse and the ready path stays combinational.
module la_dmuxn_stage #(
   parameter int unsigned WD   = 2,
   parameter string       PROP = "DEFAULT"
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [WD-1:0] i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [WD-1:0] o_data
);

   // Default cells keep the last beat's data across bubbles; other cell
   // properties use the plain stage-load enable for the data flops.
   localparam bit HOLD_ON_BUBBLE = (PROP == "DEFAULT");

   logic          r_valid;
   logic [WD-1:0] r_data;
   logic          w_load;
   logic          w_data_en;

   assign w_load    = !r_valid || i_ready;
   assign w_data_en = HOLD_ON_BUBBLE ? (w_load && i_valid) : w_load;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (w_load) begin
            r_valid <= i_valid;
         end
         if (w_data_en) begin
            r_data <= i_data;
         end
      end
   end

   assign o_ready = w_load;
   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/la_dmuxn_pipe.sv
// N-way W-bit select mux with select-violation flagging, a sticky error summary
// and a STAGES-deep valid/ready pipeline (STAGES = 0 is a pass-through).
module la_dmuxn_pipe
   import la_dmuxn_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned W      = 1,
   parameter int unsigned STAGES = 1,
   parameter string       MODE   = "ONEHOT",
   parameter string       PROP   = "DEFAULT"
) (
   input logic            clk,
   input logic            rst,
   la_dmuxn_pipe_if.slave bus
);

   localparam int unsigned DEPTH   = (STAGES > MAX_STAGES) ? MAX_STAGES : STAGES;
   localparam bit          IS_PRIO = (MODE == MODE_PRIORITY);

   logic [W-1:0] w_data;
   logic         w_viol;
   logic         w_accept;
   logic         r_sticky;

   // Element k is the link feeding stage k; element DEPTH is the output port.
   logic         w_v [DEPTH+1];
   logic         w_r [DEPTH+1];
   logic [W:0]   w_d [DEPTH+1];

   generate
      if (IS_PRIO) begin : g_prio
         // High-to-low scan: the lowest selected channel is written last and wins.
         always_comb begin
            w_data = '0;
            for (int unsigned i = N; i > 0; i--) begin
               if (bus.sel[i-1]) begin
                  w_data = bus.in[(i-1)*W +: W];
               end
            end
         end
      end else begin : g_onehot
         always_comb begin
            w_data = '0;
            for (int unsigned i = 0; i < N; i++) begin
               w_data = w_data | ({W{bus.sel[i]}} & bus.in[i*W +: W]);
            end
         end
      end
   endgenerate

   assign w_viol   = !is_onehot(SEL_MAX'(bus.sel));
   assign w_accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky <= 1'b0;
      end else if (w_accept && w_viol) begin
         r_sticky <= 1'b1;
      end else if (bus.err_clear) begin
         r_sticky <= 1'b0;
      end
   end

   assign w_v[0]       = bus.in_valid;
   assign w_d[0]       = {w_viol, w_data};
   assign w_r[DEPTH]   = bus.out_ready;
   assign bus.in_ready = w_r[0];

   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         la_dmuxn_stage #(
            .WD   (W + 1),
            .PROP (PROP)
         ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_v[k]),
            .o_ready (w_r[k]),
            .i_data  (w_d[k]),
            .o_valid (w_v[k+1]),
            .i_ready (w_r[k+1]),
            .o_data  (w_d[k+1])
         );
      end
   endgenerate

   assign bus.out_valid          = w_v[DEPTH];
   assign {bus.out_err, bus.out} = w_d[DEPTH];
   assign bus.err_sticky         = r_sticky;

endmodule
